// File: rtl/spi_slave_port_if.sv
// CPU register bus and SPI pins of the SPI slave port.
// The slave modport is the design side, master is the bus/SPI driver.
interface spi_slave_port_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;

  modport slave (
    input  spi_select, mem_addr, read_n, write_n,
    input  data_from_cpu, SCLK, SS_n, MOSI,
    output data_to_cpu, irq, MISO, MISO_oe
  );

  modport master (
    output spi_select, mem_addr, read_n, write_n,
    output data_from_cpu, SCLK, SS_n, MOSI,
    input  data_to_cpu, irq, MISO, MISO_oe
  );
endinterface

// File: rtl/spi_slave_port.sv
// Register-mapped SPI mode-0 slave, MSB first.
// SPI pins are oversampled by clk; nothing runs on SCLK.
module spi_slave_port #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  spi_slave_port_if.slave bus
);
  localparam int CW = $clog2(DATABITS + 1);
  localparam logic [15:0] CTRL_MASK = 16'h03D8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_prev, ss_prev;
  logic sclk_rise, sclk_fall, ss_fall;

  logic rd_act, wr_act, rd_prev, wr_prev;
  logic rd_stb, wr_stb;
  logic tx_wr, st_clr, ctl_wr, rx_rd;

  logic load_now, shift_now, sample_now, abort;
  logic complete, tx_accept;

  logic [CW-1:0]       bitcnt;
  logic [DATABITS-1:0] shift_tx, shift_rx;
  logic [DATABITS-1:0] tx_holding, rx_holding;
  logic                tx_full;
  logic                rrdy, roe, toe, unr;
  logic [15:0]         control;
  logic [15:0]         status;
  logic [15:0]         rd_mux;

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign ss_s   = ss_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ~ss_s & ss_prev;

  // Synchronize SPI pins and keep previous values for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr   <= '0;
      ss_sr     <= '1;
      mosi_sr   <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], bus.SCLK};
      ss_sr     <= {ss_sr[SYNC_STAGES-2:0], bus.SS_n};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], bus.MOSI};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign rd_act = bus.spi_select & ~bus.read_n;
  assign wr_act = bus.spi_select & ~bus.write_n;
  assign rd_stb = rd_act & ~rd_prev;
  assign wr_stb = wr_act & ~wr_prev;

  assign rx_rd  = rd_stb & (bus.mem_addr == 3'd0);
  assign tx_wr  = wr_stb & (bus.mem_addr == 3'd1);
  assign st_clr = wr_stb & (bus.mem_addr == 3'd2);
  assign ctl_wr = wr_stb & (bus.mem_addr == 3'd3);

  // One strobe per bus access, on its first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
    end else begin
      rd_prev <= rd_act;
      wr_prev <= wr_act;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Frame next-state: SS_n high always returns to idle.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (ss_fall) state_nx = S_SHIFT;
      S_SHIFT: if (ss_s) state_nx = S_IDLE;
               else if (complete) state_nx = S_GAP;
      S_GAP:   if (ss_s) state_nx = S_IDLE;
               else if (sclk_fall) state_nx = S_SHIFT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Frame actions decoded from state and synchronized edges.
  always_comb begin
    load_now   = 1'b0;
    shift_now  = 1'b0;
    sample_now = 1'b0;
    abort      = 1'b0;
    unique case (state)
      S_IDLE: load_now = ss_fall;
      S_SHIFT: begin
        abort      = ss_s;
        sample_now = ~ss_s & sclk_rise;
        shift_now  = ~ss_s & sclk_fall & (bitcnt != '0);
      end
      S_GAP: begin
        abort    = ss_s;
        load_now = ~ss_s & sclk_fall;
      end
      default: ;
    endcase
  end

  assign complete  = sample_now & (bitcnt == CW'(DATABITS - 1));
  // A reload frees the holding slot in the same cycle a write fills it.
  assign tx_accept = ~tx_full | load_now;

  // Shift registers, bit counter and tx/rx holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt     <= '0;
      shift_tx   <= '0;
      shift_rx   <= '0;
      tx_holding <= '0;
      rx_holding <= '0;
      tx_full    <= 1'b0;
    end else begin
      if (abort) begin
        bitcnt   <= '0;
        shift_tx <= '0;
        shift_rx <= '0;
      end else if (load_now) begin
        bitcnt   <= '0;
        shift_tx <= tx_full ? tx_holding : '0;
        if (state == S_IDLE) shift_rx <= '0;
      end else begin
        if (sample_now) begin
          shift_rx <= {shift_rx[DATABITS-2:0], mosi_s};
          bitcnt   <= complete ? '0 : bitcnt + 1'b1;
        end
        if (shift_now) shift_tx <= shift_tx << 1;
      end
      if (complete) rx_holding <= {shift_rx[DATABITS-2:0], mosi_s};
      if (tx_wr && tx_accept) begin
        tx_holding <= bus.data_from_cpu[DATABITS-1:0];
        tx_full    <= 1'b1;
      end else if (load_now) begin
        tx_full <= 1'b0;
      end
    end
  end

  // Status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrdy <= 1'b0;
      roe  <= 1'b0;
      toe  <= 1'b0;
      unr  <= 1'b0;
    end else begin
      if (complete)   rrdy <= 1'b1;
      else if (rx_rd) rrdy <= 1'b0;
      if (complete && rrdy && !rx_rd) roe <= 1'b1;
      else if (st_clr)                roe <= 1'b0;
      if (tx_wr && !tx_accept) toe <= 1'b1;
      else if (st_clr)         toe <= 1'b0;
      if (load_now && !tx_full) unr <= 1'b1;
      else if (st_clr)          unr <= 1'b0;
    end
  end

  always_comb begin
    status    = '0;
    status[3] = roe;
    status[4] = toe;
    status[5] = ~tx_full & (state == S_IDLE);
    status[6] = ~tx_full;
    status[7] = rrdy;
    status[8] = roe | toe | unr;
    status[9] = unr;
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux = '0;
    unique case (bus.mem_addr)
      3'd0:    rd_mux = {{(16 - DATABITS){1'b0}}, rx_holding};
      3'd2:    rd_mux = status;
      3'd3:    rd_mux = control;
      default: rd_mux = '0;
    endcase
  end

  // Control register, registered read data and interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control         <= '0;
      bus.data_to_cpu <= '0;
      bus.irq         <= 1'b0;
    end else begin
      if (ctl_wr) control <= bus.data_from_cpu & CTRL_MASK;
      if (rd_stb) bus.data_to_cpu <= rd_mux;
      bus.irq <= |(status & control);
    end
  end

  assign bus.MISO    = ~ss_s & shift_tx[DATABITS-1];
  assign bus.MISO_oe = ~ss_s;
endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI slave (responder) for the 8-bit SPI link, mode 0 (CPOL=0, CPHA=0), MSB first.
- Register-mapped on the same CPU bus style as the team's SPI master.
- Lets an FPGA-side CPU act as the target of an external or on-chip SPI master.
- SCLK, SS_n and MOSI are oversampled by clk, so no logic is clocked by SCLK.

Parameters:
DATABITS, 8, bits per SPI frame; the counter and shift registers are sized from it.
SYNC_STAGES, 2, synchronizer flops on SCLK, SS_n and MOSI (minimum 2).

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
spi_select  in  1  chip select for the register port.
mem_addr  in  3  register address.
read_n  in  1  active-low read.
write_n  in  1  active-low write.
data_from_cpu  in  16  write data.
data_to_cpu  out  16  registered read data.
irq  out  1  registered interrupt.
SCLK  in  1  SPI clock from the master.
SS_n  in  1  active-low slave select.
MOSI  in  1  master-out data.
MISO  out  1  slave-out data.
MISO_oe  out  1  high while selected; for a top-level tristate.

Behaviour:
- Register map:
  - 0 rxdata (r): read clears RRDY.
  - 1 txdata (w).
  - 2 status (r; any write clears ROE, TOE, UNR).
  - 3 control (r/w): irq enables.
  - Other addresses read 0.
- Status bits (upper bits read 0):
  - [3] ROE: rx overrun.
  - [4] TOE: tx write overflow.
  - [5] TMT: tx_holding empty and no frame active.
  - [6] TRDY: tx_holding empty.
  - [7] RRDY: rx byte waiting.
  - [8] E = ROE|TOE|UNR.
  - [9] UNR: frame started with no tx data.
- Control bits: [3] iROE, [4] iTOE, [6] iTRDY, [7] iRRDY, [8] iE, [9] iUNR.
- Bus accesses:
  - Each access (spi_select & ~read_n, or spi_select & ~write_n) produces exactly one strobe, in its first cycle, even when held for several cycles.
  - data_to_cpu is registered and valid one cycle after the address.
  - irq = OR of (status bit & enable), registered; one cycle after the cause.
- Synchronization: SCLK, SS_n and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronized values (current vs previous). Maximum supported SCLK is clk/8.
- Frame start: on synchronized SS_n falling edge:
  - bitcnt<=0.
  - If tx_holding full, shift_tx<=tx_holding and tx_holding empties.
  - Otherwise shift_tx<=0 and UNR<=1.
- Active frame (SS_n low):
  - SCLK rising edge: shift_rx<={shift_rx[6:0],MOSI_sync}; bitcnt++.
  - SCLK falling edge with bitcnt!=0: shift_tx<<=1.
  - MISO=shift_tx[7] and MISO_oe=1 while SS_n_sync=0; otherwise MISO=0 and MISO_oe=0.
- Byte completion, on the 8th rising edge:
  - rx_holding<={shift_rx[6:0],MOSI_sync}; RRDY<=1; ROE<=1 if RRDY was already 1 (new byte overwrites).
  - bitcnt<=0.
  - On the following falling edge, if SS_n is still low, the next byte is reloaded from tx_holding using the same rule as frame start (0 + UNR if empty). This gives back-to-back bytes with no SS_n toggle.
- TX write:
  - If TRDY, tx_holding<=data_from_cpu[7:0] and it becomes full.
  - Otherwise TOE<=1 and the data is dropped.
- SS_n rising mid-byte:
  - Partial rx bits are discarded; RRDY is unchanged.
  - The loaded tx byte is discarded; bitcnt<=0.
- Simultaneous events:
  - Byte completion and rxdata read in the same cycle: RRDY stays 1 and ROE is not set.
  - Status write and flag set in the same cycle: the set wins.
  - TX write and reload in the same cycle: the reload takes the old tx_holding and the new write fills it.
- Reset values:
  - Outputs: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0.
  - Status: all flags 0, TRDY=1, TMT=1.
  - Shift registers, rx_holding and control all 0.
  - Synchronizers reset to SS_n=1, SCLK=0, MOSI=0.
- Reset mid-frame aborts the frame immediately.

Test Plan:
1. Write txdata=0xA5; master (SCLK=clk/8) sends 0x3C in one frame -> master receives 0xA5 on MISO; rxdata=0x3C; status=0x0E0 (RRDY, TRDY, TMT).
2. Two back-to-back bytes under one SS_n low, tx writes 0x11 then 0x22 (second written after the first reload), master sends 0x81,0x42 -> MISO shows 0x11,0x22; second byte sets ROE (status bit3=1, E=1), rxdata=0x42.
3. Frame with empty tx_holding -> MISO all zeros, UNR=1; irq asserts one cycle after UNR when iUNR=1.
4. Write txdata twice without a frame -> TOE=1, tx_holding keeps the first value; any status write clears TOE/E.
5. SS_n raised after 4 SCLK edges -> RRDY stays 0; the next full frame receives its byte correctly with bitcnt restarted.
6. Assert reset mid-frame -> MISO_oe=0 and status=0x060 next cycle; operation is normal after release.
